y_multicycle_adder: RTL

//  Parametrised multi-cycle adder/subtractor; the successor to the 1-bit full adder.

---
 rtl/y_multicycle_adder.sv | 105 ++++++++++
 1 files changed

// File: rtl/y_multicycle_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, rippling the
// carry through a register, with ready/valid handshakes on both sides.
module y_multicycle_adder #(
  parameter int W     = 32,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int N  = W / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   opa_q, opb_q, z_q, z_d;
  logic           carry_q;
  logic [CW-1:0]  cnt_q;
  logic           cout_q, ovf_q, zero_q;
  logic [CHUNK:0] sum;
  logic           last;
  logic           msb_cin;

  // NOTE: every signal driven here gets a value before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    sum     = {1'b0, opa_q[cnt_q*CHUNK +: CHUNK]}
            + {1'b0, opb_q[cnt_q*CHUNK +: CHUNK]}
            + (CHUNK+1)'(carry_q);
    z_d     = z_q;
    z_d[cnt_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    last    = (cnt_q == CW'(N-1));
    // Carry into bit W-1 recovered from the top sum bit; only meaningful on the last chunk.
    msb_cin = opa_q[W-1] ^ opb_q[W-1] ^ sum[CHUNK-1];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      z_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          // Subtraction is a + ~b + 1, so invert b here and seed the carry with 1.
          opa_q   <= a;
          opb_q   <= sub ? ~b : b;
          carry_q <= sub ? 1'b1 : cin;
          cnt_q   <= '0;
        end
        RUN: begin
          z_q     <= z_d;
          carry_q <= sum[CHUNK];
          cnt_q   <= last ? '0 : cnt_q + CW'(1);
          if (last) begin
            cout_q <= sum[CHUNK];
            ovf_q  <= msb_cin ^ sum[CHUNK];
            zero_q <= (z_d == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign z         = z_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
